// File: rtl/cart_loader.sv
// Cartridge load sequencer: captures HPS download bytes into the cartridge ROM, sizes the image,
// decodes the bank-switch scheme, and (with CART_MIRROR_EN) mirrors short images up to FILL_TOP.
module cart_loader #(
  parameter int FILL_TOP = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [31:0] ioctl_file_ext,
  input  logic [1:0]  sc_mode,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [16:0] rom_size,
  output logic [3:0]  force_bs,
  output logic        sc,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef CART_MIRROR_EN
    FILL_RD,
    FILL_WR,
`endif
    DONE
  } state_t;

  localparam logic [16:0] TOP = 17'(FILL_TOP);

  state_t      state, state_n;
  logic        dl_d, rise, wr_ok;
  logic [16:0] wr_end, rom_size_n;
  logic [3:0]  bs_dec, force_bs_n;
  logic        sc_dec, sc_n, we_n, busy_n, done_n;
  logic [15:0] addr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic [23:0] ext;

  assign rise   = ioctl_download & ~dl_d;
  assign wr_ok  = ioctl_wr && (ioctl_addr[24:16] == 9'd0);
  assign wr_end = {1'b0, ioctl_addr[15:0]} + 17'd1;

  // Extension is right-aligned: either ".XY" in the low three bytes or ".XY" followed by one more char.
  assign ext    = (ioctl_file_ext[23:16] == 8'h2E) ? ioctl_file_ext[23:0] : ioctl_file_ext[31:8];
  assign sc_dec = (sc_mode == 2'd0) ? (ioctl_file_ext[7:0] == "S") : sc_mode[1];

  always_comb begin
    bs_dec = 4'd0;
    case (ext)
      ".F8": bs_dec = 4'd1;
      ".F6": bs_dec = 4'd2;
      ".FE": bs_dec = 4'd3;
      ".E0": bs_dec = 4'd4;
      ".3F": bs_dec = 4'd5;
      ".F4": bs_dec = 4'd6;
      ".P2": bs_dec = 4'd7;
      ".FA": bs_dec = 4'd8;
      ".CV": bs_dec = 4'd9;
      ".UA": bs_dec = 4'd11;
      ".E7": bs_dec = 4'd12;
      ".F0": bs_dec = 4'd13;
      ".32": bs_dec = 4'd14;
      default: bs_dec = 4'd0;
    endcase
  end

`ifdef CART_MIRROR_EN
  logic [16:0] f, f_n, fill_src;
  // During a fill write the byte read in the previous cycle is forwarded straight to the ROM.
  assign mem_wdata = (state == FILL_WR) ? mem_rdata : wdata_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_wdata    = wdata_q;
`endif

  always_comb begin
    state_n    = state;
    rom_size_n = rom_size;
    force_bs_n = force_bs;
    sc_n       = sc;
    we_n       = 1'b0;
    addr_n     = mem_addr;
    wdata_n    = wdata_q;
`ifdef CART_MIRROR_EN
    f_n        = f;
    fill_src   = f + 17'd1 - rom_size;
`endif
    if (rise) begin
      state_n    = LOAD;
      rom_size_n = 17'd0;
      force_bs_n = bs_dec;
      sc_n       = sc_dec;
    end else begin
      case (state)
        LOAD: begin
          // A write that coincides with the falling edge is committed first; LOAD ends next cycle.
          if (wr_ok) begin
            we_n    = 1'b1;
            addr_n  = ioctl_addr[15:0];
            wdata_n = ioctl_dout;
            if (wr_end > rom_size) rom_size_n = wr_end;
          end else if (!ioctl_download) begin
`ifdef CART_MIRROR_EN
            if (rom_size != 17'd0 && rom_size < TOP) begin
              state_n = FILL_RD;
              f_n     = rom_size;
              addr_n  = 16'd0;
            end else begin
              state_n = DONE;
            end
`else
            state_n = DONE;
`endif
          end
        end
`ifdef CART_MIRROR_EN
        FILL_RD: begin
          state_n = FILL_WR;
          we_n    = 1'b1;
          addr_n  = f[15:0];
        end
        FILL_WR: begin
          if (f == TOP - 17'd1) begin
            state_n = DONE;
          end else begin
            state_n = FILL_RD;
            f_n     = f + 17'd1;
            addr_n  = fill_src[15:0];
          end
        end
`endif
        DONE:    state_n = IDLE;
        default: state_n = state;
      endcase
    end
    done_n = (state_n == DONE);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dl_d     <= 1'b0;
      rom_size <= 17'd0;
      force_bs <= 4'd0;
      sc       <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 16'd0;
      wdata_q  <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef CART_MIRROR_EN
      f        <= 17'd0;
`endif
    end else begin
      state    <= state_n;
      dl_d     <= ioctl_download;
      rom_size <= rom_size_n;
      force_bs <= force_bs_n;
      sc       <= sc_n;
      mem_we   <= we_n;
      mem_addr <= addr_n;
      wdata_q  <= wdata_n;
      busy     <= busy_n;
      done     <= done_n;
`ifdef CART_MIRROR_EN
      f        <= f_n;
`endif
    end
  end

endmodule
